// File: rtl/sd_mem_fifo_ctl.sv
//------------------------------------------------------------------------------
// sd_mem_fifo_ctl
//
// Single-clock srdy/drdy FIFO controller that sits directly in front of a
// two-port behavioural RAM (behave2p_mem). It generates the RAM write strobe
// and address, and the RAM read enable and address. The RAM's own registered
// read address acts as the output stage, so read data goes straight from the
// RAM to p_data. No extra data register is needed. The FIFO sustains one word
// per cycle.
//
// Parameters
//   depth   RAM entries (power of two, >= 4)
//   width   data width in bits
//   asz     RAM address width, $clog2(depth)
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   c_srdy       write side: data valid
//   c_drdy       write side: ready, (usage < depth) & !reset
//   c_data       write data
//   p_srdy       read side: data valid
//   p_drdy       read side: downstream ready
//   p_data       read data, taken directly from mem_d_out
//   usage        words held, including the one presented on p_data
//   mem_wr_en    RAM write enable
//   mem_wr_addr  RAM write address
//   mem_d_in     RAM write data
//   mem_rd_en    RAM read enable (RAM latches mem_rd_addr on this edge)
//   mem_rd_addr  RAM read address
//   mem_d_out    RAM read data, array[latched read address]
//------------------------------------------------------------------------------
module sd_mem_fifo_ctl #(
    parameter int depth = 16,
    parameter int width = 8,
    parameter int asz   = $clog2(depth)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             c_srdy,
    output logic             c_drdy,
    input  logic [width-1:0] c_data,
    output logic             p_srdy,
    input  logic             p_drdy,
    output logic [width-1:0] p_data,
    output logic [asz:0]     usage,
    output logic             mem_wr_en,
    output logic [asz-1:0]   mem_wr_addr,
    output logic [width-1:0] mem_d_in,
    output logic             mem_rd_en,
    output logic [asz-1:0]   mem_rd_addr,
    input  logic [width-1:0] mem_d_out
);

    localparam logic [asz:0] DEPTH_U = (asz+1)'(depth);

    // The pointers carry one extra wrap bit, so the difference
    // wr - rd gives the fill level directly. Full and empty are
    // therefore distinct values.
    logic [asz:0] wr_ptr_reg;
    logic [asz:0] rd_ptr_reg;
    logic         p_srdy_reg;

    logic [asz:0] wr_ptr_next;
    logic [asz:0] rd_ptr_next;
    logic         p_srdy_next;

    logic [asz:0] stored;     // written but not yet fetched into the RAM read register
    logic         push;
    logic         fetch;

    assign stored = wr_ptr_reg - rd_ptr_reg;

    // The presented word still occupies its RAM slot until it is popped.
    // It therefore counts toward usage. This stops the writer from
    // overwriting the address that is held in the RAM read register.
    assign usage  = stored + {{asz{1'b0}}, p_srdy_reg};

    // Readiness is based only on occupancy. A pop in the same cycle does not
    // free a slot for a write at full.
    assign c_drdy = (usage < DEPTH_U) & ~reset;
    assign push   = c_srdy & c_drdy;

    // Fetch the next word when the output stage is empty, or when the
    // output stage is being emptied this cycle.
    assign fetch  = (stored != '0) & (~p_srdy_reg | p_drdy);

    assign mem_wr_en   = push;
    assign mem_wr_addr = wr_ptr_reg[asz-1:0];
    assign mem_d_in    = c_data;
    assign mem_rd_en   = fetch & ~reset;
    assign mem_rd_addr = rd_ptr_reg[asz-1:0];

    assign p_srdy = p_srdy_reg;
    assign p_data = mem_d_out;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        p_srdy_next = p_srdy_reg;

        if (push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end

        if (fetch) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
            p_srdy_next = 1'b1;
        end else if (p_srdy_reg & p_drdy) begin
            p_srdy_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            p_srdy_reg <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            p_srdy_reg <= p_srdy_next;
        end
    end

endmodule
